// File: rtl/param_processor.sv
// Four-register accumulator-style processor: fetch/exec/mem FSM over a single req/ack memory port.
// Fetch and memory phases hold their request until mem_ack; ALU ops retire one cycle after fetch.
module param_processor #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t            state, state_nxt;
  logic              run;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [4];

  logic [3:0]        op;
  logic [1:0]        rd, rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rd_val, rs_val, alu;
  logic [ADDR_W-1:0] rs_addr, br_target;
  logic [5:0]        shamt;
  logic              big_shift;

  assign op        = ir[15:12];
  assign rd        = ir[11:10];
  assign rs        = ir[9:8];
  assign imm       = ir[7:0];
  assign rd_val    = regs[rd];
  assign rs_val    = regs[rs];
  assign rs_addr   = ADDR_W'(rs_val);
  assign br_target = pc + ADDR_W'($signed(imm));
  assign shamt     = rs_val[5:0];
  assign big_shift = int'(shamt) >= DATA_W;
  assign halted    = (state == HALT);

  always_comb begin
    alu = rd_val;
    case (op)
      4'h0: alu = rd_val + rs_val;
      4'h1: alu = rd_val - rs_val;
      4'h2: alu = rd_val & rs_val;
      4'h3: alu = rd_val | rs_val;
      4'h4: alu = rd_val ^ rs_val;
      4'h5: alu = big_shift ? '0 : rd_val << shamt;
      4'h6: alu = big_shift ? '0 : rd_val >> shamt;
      4'h7: alu = DATA_W'(imm);
      default: alu = rd_val;
    endcase
  end

  // run holds the request off until the first edge after reset release
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      FETCH: begin
        if (run) begin
          mem_req  = 1'b1;
          mem_addr = pc;
          if (mem_ack) state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (op == 4'h8 || op == 4'h9) state_nxt = MEM;
        else if (op == 4'hF)          state_nxt = HALT;
        else                          state_nxt = FETCH;
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = (op == 4'h9);
        mem_addr  = rs_addr;
        mem_wdata = (op == 4'h9) ? rd_val : '0;
        if (mem_ack) state_nxt = FETCH;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      run     <= 1'b0;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      case (state)
        FETCH: begin
          if (run && mem_ack) begin
            ir <= mem_rdata[15:0];
            pc <= pc + ADDR_W'(1);
          end
        end
        EXEC: begin
          if (op <= 4'h7) regs[rd] <= alu;
          if (op == 4'hA) pc <= rs_addr;
          if (op == 4'hB && rd_val == '0) pc <= br_target;
          if (op != 4'h8 && op != 4'h9) retired <= retired + 16'd1;
        end
        MEM: begin
          if (mem_ack) begin
            if (op == 4'h8) regs[rd] <= mem_rdata;
            retired <= retired + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
